// File: rtl/keypad_scan_4x4.sv
// 4x4 key matrix scanner: rotating one-hot column drive, row read-back,
// per-frame hit evaluation and debounced press/release strobes.
// A press stable from frame start is accepted at the end of frame DEBOUNCE_FRAMES.
module keypad_scan_4x4 #(
  parameter int SCAN_DIV_W      = 15,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_pressed,
  output logic       key_released
);

  typedef enum logic [1:0] {IDLE, CAND, HELD, REL} state_t;

  localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

  logic [3:0]            row_m;
  logic [3:0]            row_s;
  logic [SCAN_DIV_W-1:0] div;
  logic [1:0]            col_idx;
  logic                  slot_end;
  logic                  frame_end;

  // Frame accumulators: hit count saturates at 2, since only 0/1/many matter
  logic [1:0]            acc_hits;
  logic [3:0]            acc_code;

  logic [2:0]            slot_hits;
  logic [1:0]            row_hit_idx;
  logic [2:0]            hit_sum;
  logic [1:0]            hits_sat;
  logic [3:0]            frame_code;
  logic                  res_none;
  logic                  res_key;

  state_t                state;
  logic [3:0]            cnt;
  logic [3:0]            cnt_inc;
  logic [3:0]            cand;

  assign slot_end  = &div;
  assign frame_end = slot_end && (col_idx == 2'd3);
  assign cnt_inc   = cnt + 4'd1;

  // Two-stage synchronizer for the asynchronous row lines
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_m <= 4'b0;
      row_s <= 4'b0;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  // Free-running slot divider and column rotation on each slot end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div     <= '0;
      col     <= 4'b0001;
      col_idx <= 2'd0;
    end else begin
      div <= div + 1'b1;
      if (slot_end) begin
        col     <= {col[2:0], col[3]};
        col_idx <= col_idx + 2'd1;
      end
    end
  end

  // Count rows hit in the current column and locate one of them
  always_comb begin
    slot_hits   = 3'(row_s[0]) + 3'(row_s[1]) + 3'(row_s[2]) + 3'(row_s[3]);
    row_hit_idx = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (row_s[r]) row_hit_idx = 2'(r);
    end
    hit_sum    = 3'(acc_hits) + slot_hits;
    hits_sat   = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
    frame_code = (slot_hits != 3'd0) ? {col_idx, row_hit_idx} : acc_code;
    res_none   = (hits_sat == 2'd0);
    res_key    = (hits_sat == 2'd1);
  end

  // Accumulate hits across the frame; clear as the frame result is consumed
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_hits <= 2'd0;
      acc_code <= 4'd0;
    end else if (slot_end) begin
      if (col_idx == 2'd3) begin
        acc_hits <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_hits <= hits_sat;
        acc_code <= frame_code;
      end
    end
  end

  // Debounce FSM with registered key outputs; strobes last one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      cand         <= 4'd0;
      key_value    <= 4'd0;
      key_valid    <= 1'b0;
      key_pressed  <= 1'b0;
      key_released <= 1'b0;
    end else begin
      key_pressed  <= 1'b0;
      key_released <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (res_key) begin
              cand <= frame_code;
              if (DEB <= 4'd1) begin
                state       <= HELD;
                cnt         <= 4'd0;
                key_value   <= frame_code;
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
              end else begin
                state <= CAND;
                cnt   <= 4'd1;
              end
            end
          end
          CAND: begin
            if (res_key && frame_code == cand) begin
              if (cnt_inc >= DEB) begin
                state       <= HELD;
                cnt         <= 4'd0;
                key_value   <= cand;
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (res_key) begin
              cand <= frame_code;
              cnt  <= 4'd1;
            end else begin
              state <= IDLE;
              cnt   <= 4'd0;
            end
          end
          HELD: begin
            if (res_none || (res_key && frame_code != key_value)) begin
              if (DEB <= 4'd1) begin
                state        <= IDLE;
                cnt          <= 4'd0;
                key_valid    <= 1'b0;
                key_released <= 1'b1;
              end else begin
                state <= REL;
                cnt   <= 4'd1;
              end
            end
          end
          REL: begin
            if (res_none || (res_key && frame_code != key_value)) begin
              if (cnt_inc >= DEB) begin
                state        <= IDLE;
                cnt          <= 4'd0;
                key_valid    <= 1'b0;
                key_released <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= HELD;
              cnt   <= 4'd0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: a matrix model turns a pressed-key mask into row
// lines for the driven column; a streak-based debounce model predicts outputs.
module tb_keypad_scan_4x4;

  localparam int DIVW = 2;
  localparam int DEB  = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_pressed;
  logic       key_released;

  logic [15:0] keys;

  int total = 0;
  int bad   = 0;

  // Reference model state (frame-level)
  bit       m_held;
  bit [3:0] m_kv;
  int       press_run;
  bit [3:0] press_code;
  int       away_run;

  keypad_scan_4x4 #(.SCAN_DIV_W(DIVW), .DEBOUNCE_FRAMES(DEB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .row          (row),
    .col          (col),
    .key_value    (key_value),
    .key_valid    (key_valid),
    .key_pressed  (key_pressed),
    .key_released (key_released)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key connects its column drive to its row line
  always_comb begin
    row = 4'b0;
    for (int c = 0; c < 4; c++) begin
      if (col[c]) row = row | keys[c*4 +: 4];
    end
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_held     = 1'b0;
    m_kv       = 4'd0;
    press_run  = 0;
    press_code = 4'd0;
    away_run   = 0;
  endtask

  // Frame result: 0 keys = none, 1 key = that code, more = multi
  task automatic model_frame(input logic [15:0] m, output bit ep, output bit er);
    int       n;
    bit [3:0] code;
    n    = $countones(m);
    code = 4'd0;
    for (int k = 0; k < 16; k++) if (m[k]) code = 4'(k);
    ep = 1'b0;
    er = 1'b0;
    if (!m_held) begin
      if (n == 1) begin
        if (press_run > 0 && code == press_code) press_run++;
        else begin
          press_code = code;
          press_run  = 1;
        end
        if (press_run >= DEB) begin
          m_held    = 1'b1;
          m_kv      = code;
          ep        = 1'b1;
          press_run = 0;
          away_run  = 0;
        end
      end else begin
        press_run = 0;
      end
    end else begin
      if (n == 0 || (n == 1 && code != m_kv)) begin
        away_run++;
        if (away_run >= DEB) begin
          m_held    = 1'b0;
          er        = 1'b1;
          away_run  = 0;
          press_run = 0;
        end
      end else begin
        away_run = 0;
      end
    end
  endtask

  // One frame of 16 clocks with mask m, starting just after a frame boundary
  task automatic frame(input logic [15:0] m);
    bit         ep, er;
    bit         prev_valid;
    bit   [3:0] prev_kv;
    logic [3:0] onehot;
    prev_valid = m_held;
    prev_kv    = m_kv;
    keys       = m;
    model_frame(m, ep, er);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      onehot = 4'b0001;
      onehot = onehot << ((i / 4) % 4);
      chk("col", col, onehot);
      if (i < 16) begin
        chk("pressed_mid", {3'b0, key_pressed}, 4'd0);
        chk("released_mid", {3'b0, key_released}, 4'd0);
        chk("valid_mid", {3'b0, key_valid}, {3'b0, prev_valid});
        chk("value_mid", key_value, prev_kv);
      end else begin
        chk("pressed_end", {3'b0, key_pressed}, {3'b0, ep});
        chk("released_end", {3'b0, key_released}, {3'b0, er});
        chk("valid_end", {3'b0, key_valid}, {3'b0, m_held});
        chk("value_end", key_value, m_kv);
      end
    end
  endtask

  initial begin
    logic [15:0] m;
    logic [15:0] last_m;
    int          r;
    reset_n = 1'b0;
    keys    = 16'h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_col", col, 4'b0001);
    chk("rst_value", key_value, 4'd0);
    chk("rst_valid", {3'b0, key_valid}, 4'd0);
    chk("rst_pressed", {3'b0, key_pressed}, 4'd0);
    chk("rst_released", {3'b0, key_released}, 4'd0);
    reset_n = 1'b1;

    // Single press col2/row1 (code 9), then release
    repeat (3) frame(16'h1 << 9);
    chk("single_value", key_value, 4'b1001);
    repeat (3) frame(16'h0);
    chk("single_rel_value", key_value, 4'b1001);

    // Bounce on col0/row3 (code 3): 2 present, 1 absent, 3 present
    repeat (2) frame(16'h1 << 3);
    frame(16'h0);
    repeat (3) frame(16'h1 << 3);
    chk("bounce_value", key_value, 4'b0011);
    repeat (3) frame(16'h0);

    // Ghost pair from idle: codes 4 and 14 together
    repeat (4) frame((16'h1 << 4) | (16'h1 << 14));
    frame(16'h0);

    // Hold code 4, then add code 14 while held
    repeat (3) frame(16'h1 << 4);
    repeat (3) frame((16'h1 << 4) | (16'h1 << 14));
    chk("multi_held_value", key_value, 4'b0100);

    // Release glitch: absent 2 frames, then back
    repeat (2) frame(16'h0);
    repeat (2) frame(16'h1 << 4);
    chk("glitch_valid", {3'b0, key_valid}, 4'd1);

    // Reset while held: outputs clear with no release strobe, then re-accept
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_col", col, 4'b0001);
    chk("mid_rst_value", key_value, 4'd0);
    chk("mid_rst_valid", {3'b0, key_valid}, 4'd0);
    chk("mid_rst_pressed", {3'b0, key_pressed}, 4'd0);
    chk("mid_rst_released", {3'b0, key_released}, 4'd0);
    reset_n = 1'b1;
    model_reset();
    repeat (3) frame(16'h1 << 4);
    chk("reaccept_value", key_value, 4'b0100);
    repeat (3) frame(16'h0);

    // Randomized frames mixing idle, repeated keys, stray keys and multi
    last_m = 16'h0;
    for (int f = 0; f < 60; f++) begin
      r = $urandom_range(0, 7);
      case (r)
        0, 1:    m = 16'h0;
        2, 3:    m = 16'h1 << 5;
        4:       m = 16'h1 << 10;
        5:       m = 16'h1 << $urandom_range(0, 15);
        6:       m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: m = last_m;
      endcase
      frame(m);
      last_m = m;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
